// File: rtl/sound_sequencer.sv
// Speaker-mux code generator for the Tug-of-War game.
// Turns outcome pulses into timed, prioritised sound playback.
module sound_sequencer #(
  parameter int ROUND_CYCLES = 50_000_000,
  parameter int VICT_CYCLES  = 150_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       round_win,
  input  logic       round_lose,
  input  logic       game_win,
  input  logic       mute,
  output logic [1:0] sound_control,
  output logic       busy,
  output logic       done
);

  localparam int MAXC = (ROUND_CYCLES > VICT_CYCLES) ?
                        ROUND_CYCLES : VICT_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] RLOAD = CW'(ROUND_CYCLES - 1);
  localparam logic [CW-1:0] VLOAD = CW'(VICT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WIN  = 2'b01,
    LOSE = 2'b10,
    VICT = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_ev_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_ev_load;
  logic          w_ev_valid;
  logic [1:0]    w_ev_prio;
  logic [1:0]    w_cur_prio;
  logic          w_accept;
  logic          w_done_nxt;
  logic          r_busy;
  logic          r_done;

  // Rank differs from encoding: WIN outranks LOSE.
  always_comb begin
    w_cur_prio = 2'd0;
    case (r_state)
      IDLE:    w_cur_prio = 2'd0;
      LOSE:    w_cur_prio = 2'd1;
      WIN:     w_cur_prio = 2'd2;
      VICT:    w_cur_prio = 2'd3;
      default: w_cur_prio = 2'd0;
    endcase
  end

  always_comb begin
    w_ev_valid = 1'b1;
    w_ev_state = IDLE;
    w_ev_prio  = 2'd0;
    w_ev_load  = RLOAD;
    if (game_win) begin
      w_ev_state = VICT;
      w_ev_prio  = 2'd3;
      w_ev_load  = VLOAD;
    end else if (round_win) begin
      w_ev_state = WIN;
      w_ev_prio  = 2'd2;
    end else if (round_lose) begin
      w_ev_state = LOSE;
      w_ev_prio  = 2'd1;
    end else begin
      w_ev_valid = 1'b0;
    end
  end

  assign w_accept = w_ev_valid && (w_ev_prio >= w_cur_prio);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (mute) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      w_state_nxt = w_ev_state;
      w_cnt_nxt   = w_ev_load;
    end else if (r_state != IDLE) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CW'(1);
      end else begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign sound_control = r_state;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer (ROUND=8, VICT=20).
// Expected {code,busy,done} per cycle are queued as stimulus is driven.
module tb_sound_sequencer;

  logic       clk;
  logic       rst;
  logic       round_win;
  logic       round_lose;
  logic       game_win;
  logic       mute;
  logic [1:0] sound_control;
  logic       busy;
  logic       done;

  int         n_tests;
  int         n_fail;
  string      tag_s;
  logic [3:0] sb_q[$];

  localparam logic [2:0] EV_NONE = 3'b000;
  localparam logic [2:0] EV_RW   = 3'b100;
  localparam logic [2:0] EV_RL   = 3'b010;
  localparam logic [2:0] EV_GW   = 3'b001;
  localparam logic [2:0] EV_ALL  = 3'b111;

  sound_sequencer #(
    .ROUND_CYCLES(8),
    .VICT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .round_win    (round_win),
    .round_lose   (round_lose),
    .game_win     (game_win),
    .mute         (mute),
    .sound_control(sound_control),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] code,
                      input logic b,
                      input logic d,
                      input int n);
    for (int i = 0; i < n; i++) sb_q.push_back({code, b, d});
  endtask

  // Drive one cycle of inputs, then compare outputs at the falling edge.
  task automatic cyc(input logic [2:0] ev, input logic m);
    logic [3:0] e;
    {round_win, round_lose, game_win} = ev;
    mute = m;
    @(posedge clk);
    @(negedge clk);
    chk({tag_s, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(tag_s, 32'({sound_control, busy, done}), 32'(e));
    end
  endtask

  task automatic play(input logic [2:0] ev,
                      input logic [1:0] code,
                      input int n);
    push(code, 1'b1, 1'b0, n);
    push(2'b00, 1'b0, 1'b1, 1);
    cyc(ev, 1'b0);
    for (int i = 0; i < n; i++) cyc(EV_NONE, 1'b0);
  endtask

  task automatic idle(input int n);
    push(2'b00, 1'b0, 1'b0, n);
    for (int i = 0; i < n; i++) cyc(EV_NONE, 1'b0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    round_win  = 1'b0;
    round_lose = 1'b0;
    game_win   = 1'b0;
    mute       = 1'b0;

    tag_s = "reset";
    #3 rst = 1'b1;
    #1;
    chk("reset_async", 32'({sound_control, busy, done}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_hold", 32'({sound_control, busy, done}), 32'h0);
    rst = 1'b0;
    idle(2);

    tag_s = "basic_win";
    play(EV_RW, 2'b01, 8);
    idle(2);

    tag_s = "priority";
    play(EV_ALL, 2'b11, 20);
    idle(1);

    tag_s = "preempt";
    push(2'b10, 1'b1, 1'b0, 3);
    cyc(EV_RL, 1'b0);
    cyc(EV_NONE, 1'b0);
    cyc(EV_NONE, 1'b0);
    play(EV_RW, 2'b01, 8);
    idle(1);

    tag_s = "drop";
    push(2'b11, 1'b1, 1'b0, 20);
    push(2'b00, 1'b0, 1'b1, 1);
    cyc(EV_GW, 1'b0);
    for (int i = 0; i < 4; i++) cyc(EV_NONE, 1'b0);
    cyc(EV_RW, 1'b0);
    for (int i = 0; i < 15; i++) cyc(EV_NONE, 1'b0);
    idle(1);

    tag_s = "restart_end";
    push(2'b01, 1'b1, 1'b0, 16);
    push(2'b00, 1'b0, 1'b1, 1);
    cyc(EV_RW, 1'b0);
    for (int i = 0; i < 7; i++) cyc(EV_NONE, 1'b0);
    cyc(EV_RW, 1'b0);
    for (int i = 0; i < 8; i++) cyc(EV_NONE, 1'b0);
    idle(1);

    tag_s = "mute";
    push(2'b11, 1'b1, 1'b0, 5);
    push(2'b00, 1'b0, 1'b0, 3);
    cyc(EV_GW, 1'b0);
    for (int i = 0; i < 4; i++) cyc(EV_NONE, 1'b0);
    cyc(EV_GW, 1'b1);
    cyc(EV_NONE, 1'b1);
    cyc(EV_NONE, 1'b1);
    idle(25);

    tag_s = "async_rst";
    push(2'b01, 1'b1, 1'b0, 4);
    cyc(EV_RW, 1'b0);
    for (int i = 0; i < 3; i++) cyc(EV_NONE, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_now", 32'({sound_control, busy, done}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("async_rst_hold", 32'({sound_control, busy, done}), 32'h0);
    rst = 1'b0;
    idle(1);
    tag_s = "post_rst_lose";
    play(EV_RL, 2'b10, 8);
    idle(1);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Generates the 2-bit `sound_control` code that drives the speaker multiplexer, turning one-cycle game-event pulses into timed sound playback. Sits between the Tug-of-War game controller (round/game outcome pulses) and the speaker mux. It arbitrates simultaneous events by priority and holds each selection for a fixed number of clock cycles. It then returns the speaker to off.

## Interface
- `ROUND_CYCLES`, default 50_000_000: playback length, in clocks, of the round-win and round-lose sounds; must be ≥1.
- `VICT_CYCLES`, default 150_000_000: playback length, in clocks, of the victory sound; must be ≥1.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `round_win`  input  1  one-cycle pulse: player won a round.
- `round_lose`  input  1  one-cycle pulse: player lost a round.
- `game_win`  input  1  one-cycle pulse: player won the game.
- `mute`  input  1  level; while high, all playback is suppressed.
- `sound_control`  output  2  code to the speaker mux: 00 off, 01 round win, 10 round lose, 11 victory. Registered.
- `busy`  output  1  high while a sound is playing (`sound_control != 00`). Registered.
- `done`  output  1  one-cycle pulse when a sound finishes its full duration. Registered.

## Operation
- Four states, with encoding equal to `sound_control`:
  - IDLE (00)
  - WIN (01)
  - LOSE (10)
  - VICT (11)
- Down-counter `cnt`, width `$clog2(max(ROUND_CYCLES,VICT_CYCLES))` (minimum 1 bit).
- Event priority: `game_win` > `round_win` > `round_lose`. When several events are high in the same cycle, only the highest-priority one is taken.
- Accepting an event:
  - An event is accepted when its priority is ≥ the priority of the current state. IDLE has the lowest priority.
  - On acceptance, the state becomes the event's state.
  - `cnt` loads `ROUND_CYCLES-1` for WIN/LOSE, or `VICT_CYCLES-1` for VICT.
  - An equal-priority event restarts the sound, including reloading the counter.
- Lower-priority events arriving while a sound plays are dropped, not queued.
- Outside an accepted event:
  - In a non-IDLE state with `cnt != 0`, `cnt` decrements.
  - In a non-IDLE state with `cnt == 0`, the state goes to IDLE and `done` pulses for one cycle.
- An event accepted in the same cycle that `cnt == 0` takes precedence: the state reloads and no `done` pulse is issued.
- `mute` high forces the next state to IDLE with `cnt` = 0. Events are ignored while `mute` is high, and no `done` is issued. Deasserting `mute` does not resume the interrupted sound.
- `busy` = (next state != IDLE), registered alongside the state.

## Timing
- Reset (asynchronous, active-high) sets `sound_control` = 00, `busy` = 0, `done` = 0, state = IDLE, `cnt` = 0. Reset asserted mid-playback stops the sound immediately, without waiting for a clock edge.
- Event latency: an event sampled high at rising edge k gives a new `sound_control` from edge k onward, i.e. visible in cycle k+1.
- Duration: an uninterrupted sound holds `sound_control` for exactly N clock cycles, where N is `ROUND_CYCLES` or `VICT_CYCLES`. `sound_control` returns to 00 at edge k+N, and `done` is high for the single cycle following edge k+N.
- With N = 1, the sound lasts one cycle and `done` follows immediately after.
- Events pulsed for more than one cycle are treated as repeated restarts. The upstream controller must issue single-cycle pulses.
- `mute` takes effect at the next rising edge: `sound_control` = 00 one cycle after `mute` is sampled high.
- No combinational path exists from inputs to outputs.

## Test plan
Benches use `ROUND_CYCLES` = 8 and `VICT_CYCLES` = 20.

- **Reset and basic playback:** assert `rst` mid-cycle, then release; pulse `round_win` at edge 0 → `sound_control` = 01 for cycles 1–8, `busy` = 1, then 00 at edge 8 with `done` = 1 for one cycle; outputs are 00/0/0 during reset.
- **Priority:** pulse `round_win`, `round_lose` and `game_win` in the same cycle → `sound_control` = 11 for 20 cycles, then one `done` pulse.
- **Preemption and drop:** start `round_lose`; 3 cycles later pulse `round_win` → `sound_control` = 01, held 8 cycles from the `round_win` edge. During VICT, pulse `round_win` → no change, VICT completes its 20 cycles.
- **Restart and end-boundary:** pulse `round_win`, then pulse it again in the cycle where `cnt` = 0 → no `done`, and 01 is held for 8 further cycles.
- **Mute:** during VICT at cycle 5, raise `mute` for 3 cycles while pulsing `game_win` → 00 from the next cycle, no `done`, and the event is ignored; after `mute` drops, `sound_control` stays 00.
- **Async reset mid-sound:** assert `rst` at cycle 4 of WIN, between clock edges → `sound_control` = 00 and `busy` = 0 immediately; after release, the block is IDLE and the next `round_lose` plays normally for 8 cycles.
